// File: rtl/init_pop_param.sv
// Population initialiser: seeds a 32-bit Galois LFSR and fills the population CHUNK_W bits per cycle.
// Optional macro INIT_POP_NONZERO_EN adds a FIX pass that forces every all-zero genome to 1.
module init_pop_param #(
    parameter int GENOME_W    = 8,
    parameter int NUM_GENOMES = 16,
    parameter int CHUNK_W     = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [31:0]                     seed,
    output logic [GENOME_W*NUM_GENOMES-1:0] population,
    output logic                            busy,
    output logic                            done
);
    localparam int POP_W    = GENOME_W * NUM_GENOMES;
    localparam int N_CHUNKS = (POP_W + CHUNK_W - 1) / CHUNK_W;
    localparam int CNT_W    = $clog2(N_CHUNKS + 1);
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

`ifdef INIT_POP_NONZERO_EN
    localparam int IDX_W = $clog2(NUM_GENOMES + 1);
    typedef enum logic [1:0] {S_IDLE, S_FILL, S_FIX, S_DONE} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;
`endif

    state_t             state_q, state_d;
    logic [31:0]        lfsr_q, lfsr_d;
    logic [POP_W-1:0]   pop_q, pop_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        lfsr_step;
    logic [POP_W+CHUNK_W-1:0] pop_shifted;
`ifdef INIT_POP_NONZERO_EN
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [31:0]        fix_base;
`endif

    always_comb begin
        lfsr_step   = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 32'h0);
        // Concatenation gives shift-in-and-truncate; early chunk MSBs fall off the top.
        pop_shifted = {pop_q, lfsr_step[CHUNK_W-1:0]};
    end

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        pop_d   = pop_q;
        cnt_d   = cnt_q;
        busy    = 1'b1;
        done    = 1'b0;
`ifdef INIT_POP_NONZERO_EN
        idx_d    = idx_q;
        fix_base = 32'(idx_q) * GENOME_W;
`endif
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    lfsr_d  = (seed == 32'h0) ? 32'h1 : seed;
                    pop_d   = '0;
                    cnt_d   = '0;
`ifdef INIT_POP_NONZERO_EN
                    idx_d   = '0;
`endif
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                lfsr_d = lfsr_step;
                pop_d  = pop_shifted[POP_W-1:0];
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(N_CHUNKS - 1)) begin
`ifdef INIT_POP_NONZERO_EN
                    state_d = S_FIX;
`else
                    state_d = S_DONE;
`endif
                end
            end
`ifdef INIT_POP_NONZERO_EN
            S_FIX: begin
                if (pop_q[fix_base +: GENOME_W] == '0)
                    pop_d[fix_base +: GENOME_W] = GENOME_W'(1);
                idx_d = idx_q + 1'b1;
                if (idx_q == IDX_W'(NUM_GENOMES - 1))
                    state_d = S_DONE;
            end
`endif
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            lfsr_q  <= 32'h1;
            pop_q   <= '0;
            cnt_q   <= '0;
`ifdef INIT_POP_NONZERO_EN
            idx_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            pop_q   <= pop_d;
            cnt_q   <= cnt_d;
`ifdef INIT_POP_NONZERO_EN
            idx_q   <= idx_d;
`endif
        end
    end

    assign population = pop_q;

endmodule

// File: tb/tb_init_pop_param.sv
// Bench for init_pop_param: three parameter sets checked against a behavioural population model.
module tb_init_pop_param;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  start = 3'b000;
    logic [31:0] seed [3];
    logic [31:0] pop_a;
    logic [14:0] pop_b;
    logic [7:0]  pop_c;
    logic [2:0]  busy;
    logic [2:0]  done;

    int checks   = 0;
    int failures = 0;

    localparam int GW [3] = '{8, 5, 2};
    localparam int NG [3] = '{4, 3, 4};
    localparam int CW [3] = '{8, 4, 8};

    always #5 clk = ~clk;

    init_pop_param #(.GENOME_W(8), .NUM_GENOMES(4), .CHUNK_W(8)) u_a (
        .clk(clk), .rst(rst), .start(start[0]), .seed(seed[0]),
        .population(pop_a), .busy(busy[0]), .done(done[0]));
    init_pop_param #(.GENOME_W(5), .NUM_GENOMES(3), .CHUNK_W(4)) u_b (
        .clk(clk), .rst(rst), .start(start[1]), .seed(seed[1]),
        .population(pop_b), .busy(busy[1]), .done(done[1]));
    init_pop_param #(.GENOME_W(2), .NUM_GENOMES(4), .CHUNK_W(8)) u_c (
        .clk(clk), .rst(rst), .start(start[2]), .seed(seed[2]),
        .population(pop_c), .busy(busy[2]), .done(done[2]));

    function automatic logic [31:0] get_pop(input int d);
        case (d)
            0:       return pop_a;
            1:       return {17'b0, pop_b};
            default: return {24'b0, pop_c};
        endcase
    endfunction

    function automatic int n_chunks(input int d);
        return (GW[d] * NG[d] + CW[d] - 1) / CW[d];
    endfunction

    // cycles from the start-sampling edge to the negedge where done is seen
    function automatic int model_lat(input int d);
        int lat;
        lat = n_chunks(d) + 1;
`ifdef INIT_POP_NONZERO_EN
        lat += NG[d];
`endif
        return lat;
    endfunction

    function automatic logic [31:0] model_pop(input int d, input logic [31:0] sd);
        logic [31:0] s;
        logic [63:0] p, pmask, cmask, gmask;
        int popw;
        popw  = GW[d] * NG[d];
        pmask = (64'h1 << popw) - 64'h1;
        cmask = (64'h1 << CW[d]) - 64'h1;
        gmask = (64'h1 << GW[d]) - 64'h1;
        s = (sd == 32'h0) ? 32'h1 : sd;
        p = 64'h0;
        for (int c = 0; c < n_chunks(d); c++) begin
            if (s[0]) s = (s >> 1) ^ 32'h8020_0003;
            else      s = s >> 1;
            p = ((p << CW[d]) | ({32'h0, s} & cmask)) & pmask;
        end
`ifdef INIT_POP_NONZERO_EN
        for (int i = 0; i < NG[d]; i++)
            if (((p >> (i * GW[d])) & gmask) == 64'h0)
                p = p | (64'h1 << (i * GW[d]));
`endif
        return p[31:0];
    endfunction

    task automatic do_run(input int d, input logic [31:0] sd, input logic [31:0] exp_pop,
                          input bit mid_pulse, input logic [31:0] sd2, input string name);
        int  lat, k;
        bit  seen;
        lat = model_lat(d);
        @(negedge clk);
        seed[d]  = sd;
        start[d] = 1'b1;
        @(negedge clk);
        start[d] = 1'b0;
        seed[d]  = $urandom;
        checks++;
        if (busy[d] !== 1'b1) begin
            failures++;
            $display("FAIL %s busy_rise: got %b want 1", name, busy[d]);
        end
        seen = 1'b0;
        k = 1;
        while (!seen && k <= lat + 20) begin
            if (done[d] === 1'b1) begin
                seen = 1'b1;
                checks++;
                if (k != lat) begin
                    failures++;
                    $display("FAIL %s latency: got %0d want %0d", name, k, lat);
                end
                checks++;
                if (get_pop(d) !== exp_pop) begin
                    failures++;
                    $display("FAIL %s population: got %h want %h", name, get_pop(d), exp_pop);
                end
            end else begin
                if (mid_pulse && k == 2) begin
                    start[d] = 1'b1;
                    seed[d]  = sd2;
                end else if (mid_pulse && k == 3) begin
                    start[d] = 1'b0;
                end
                @(negedge clk);
                k++;
            end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s done_timeout: got none want done at %0d", name, lat);
        end else begin
            @(negedge clk);
            checks++;
            if (done[d] !== 1'b0 || busy[d] !== 1'b0 || get_pop(d) !== exp_pop) begin
                failures++;
                $display("FAIL %s after_done: got done=%b busy=%b pop=%h want 0 0 %h",
                         name, done[d], busy[d], get_pop(d), exp_pop);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start[0] = 1'b1;
        seed[0] = 32'h1234;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (get_pop(d) !== 32'h0 || busy[d] !== 1'b0 || done[d] !== 1'b0) begin
                failures++;
                $display("FAIL reset_state[%0d]: got pop=%h busy=%b done=%b want 0 0 0",
                         d, get_pop(d), busy[d], done[d]);
            end
        end
        start[0] = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_known_vectors();
        logic [31:0] exp_c;
`ifdef INIT_POP_NONZERO_EN
        exp_c = 32'h57;
`else
        exp_c = 32'h03;
`endif
        do_run(0, 32'h1, 32'h0302_0103, 1'b0, 32'h0, "vec_8x4_c8");
        do_run(1, 32'h1, 32'h0000_3213, 1'b0, 32'h0, "vec_5x3_c4");
        do_run(2, 32'h1, exp_c,         1'b0, 32'h0, "vec_2x4_c8");
    endtask

    task automatic test_zero_seed();
        do_run(0, 32'h0, 32'h0302_0103, 1'b0, 32'h0, "zero_seed");
    endtask

    task automatic test_random();
        logic [31:0] sd;
        for (int i = 0; i < 6; i++) begin
            for (int d = 0; d < 3; d++) begin
                sd = $urandom;
                if (i == 0) sd = sd & 32'h0000_00f0;
                do_run(d, sd, model_pop(d, sd), 1'b0, 32'h0, $sformatf("random[%0d][%0d]", d, i));
            end
        end
    endtask

    task automatic test_reset_mid_fill();
        bit pulsed;
        @(negedge clk);
        seed[0]  = 32'hdead_beef;
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (get_pop(0) !== 32'h0 || busy[0] !== 1'b0 || done[0] !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_fill: got pop=%h busy=%b done=%b want 0 0 0",
                     get_pop(0), busy[0], done[0]);
        end
        pulsed = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (done[0] === 1'b1 || busy[0] === 1'b1) pulsed = 1'b1;
        end
        checks++;
        if (pulsed) begin
            failures++;
            $display("FAIL rst_no_done: got activity after reset want none");
        end
        do_run(0, 32'h1, 32'h0302_0103, 1'b0, 32'h0, "after_rst");
    endtask

    task automatic test_start_ignored();
        logic [31:0] sa, sb;
        sa = $urandom | 32'h1;
        sb = sa ^ 32'h5a5a_0f0f;
        do_run(0, sa, model_pop(0, sa), 1'b1, sb, "start_ignored");
    endtask

    task automatic test_back_to_back();
        logic [31:0] sd;
        int          last_k, n_done, k;
        sd = $urandom;
        @(negedge clk);
        seed[0]  = sd;
        start[0] = 1'b1;
        last_k = 0;
        n_done = 0;
        k = 0;
        while (n_done < 3 && k < 80) begin
            @(negedge clk);
            k++;
            if (done[0] === 1'b1) begin
                checks++;
                if (n_done == 0) begin
                    if (k != model_lat(0)) begin
                        failures++;
                        $display("FAIL b2b_first: got %0d want %0d", k, model_lat(0));
                    end
                end else if (k - last_k != model_lat(0) + 1) begin
                    failures++;
                    $display("FAIL b2b_spacing: got %0d want %0d", k - last_k, model_lat(0) + 1);
                end
                checks++;
                if (get_pop(0) !== model_pop(0, sd)) begin
                    failures++;
                    $display("FAIL b2b_population: got %h want %h", get_pop(0), model_pop(0, sd));
                end
                last_k = k;
                n_done++;
            end
        end
        start[0] = 1'b0;
        checks++;
        if (n_done != 3) begin
            failures++;
            $display("FAIL b2b_count: got %0d want 3", n_done);
        end
        repeat (model_lat(0) + 3) @(negedge clk);
    endtask

    initial begin
        for (int d = 0; d < 3; d++) seed[d] = 32'h0;
        test_reset();
        test_known_vectors();
        test_zero_seed();
        test_random();
        test_reset_mid_fill();
        test_start_ignored();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion want finish before 200000");
        $fatal(1, "watchdog expired");
    end
endmodule
